// File: rtl/temp_pkg.sv
// Shared types and constants for the periodic temperature sampling controller.
// Width of the temperature path, FSM state type and default timing constants.
package temp_pkg;

    localparam int TC_W               = 13;
    localparam int SUM_W              = 15;
    localparam int DEF_SAMPLE_PERIOD  = 100_000_000;
    localparam int DEF_ACK_TIMEOUT    = 1000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } temp_state_t;

    // Counter width for a 0..n-1 counter; a single-count counter still needs one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/temp_avg4.sv
// Four-entry running averager of captured two's-complement temperature samples.
// The first load after reset primes every entry with that sample.
module temp_avg4
    import temp_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic [TC_W-1:0] sample,
    output logic [TC_W-1:0] avg
);

    logic [TC_W-1:0]         hist [4];
    logic                    primed;
    logic signed [SUM_W-1:0] sum;
    logic signed [SUM_W-1:0] shifted;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) hist[i] <= '0;
            primed <= 1'b0;
        end else if (load) begin
            if (!primed) begin
                for (int i = 0; i < 4; i++) hist[i] <= sample;
            end else begin
                hist[0] <= sample;
                hist[1] <= hist[0];
                hist[2] <= hist[1];
                hist[3] <= hist[2];
            end
            primed <= 1'b1;
        end
    end

    always_comb begin
        sum = '0;
        for (int i = 0; i < 4; i++) sum = sum + SUM_W'($signed(hist[i]));
        shifted = sum >>> 2;
        avg     = shifted[TC_W-1:0];
    end

endmodule

// File: rtl/temp_sample_ctrl.sv
// Periodic sample requester: IDLE -> REQ -> WAIT loop with acknowledge timeout.
// Define TEMP_AVG_EN to present a 4-sample running average on tc instead of the latest sample.
module temp_sample_ctrl
    import temp_pkg::*;
#(
    parameter int SAMPLE_PERIOD = DEF_SAMPLE_PERIOD,
    parameter int ACK_TIMEOUT   = DEF_ACK_TIMEOUT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            enable,
    input  logic            units_toggle,
    output logic            sample_req,
    input  logic            sample_ack,
    input  logic [TC_W-1:0] sample_data,
    output logic [TC_W-1:0] tc,
    output logic            c_f,
    output logic            valid,
    output logic            timeout,
    output temp_state_t     fsm_state
);

    // Handshake: sample_req is held high for the whole REQ state; a one-cycle
    // sample_ack while in REQ (and enabled) completes it, data valid that cycle.

    localparam int TO_W = cnt_w(ACK_TIMEOUT);
    localparam int WT_W = cnt_w(SAMPLE_PERIOD);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACK_TIMEOUT - 1);
    localparam logic [WT_W-1:0] WT_LAST = WT_W'(SAMPLE_PERIOD - 1);

    temp_state_t     state;
    temp_state_t     state_nx;
    logic [TO_W-1:0] to_cnt;
    logic [WT_W-1:0] wt_cnt;
    logic            capture;
    logic            expire;

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (!enable) begin
            state_nx = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: state_nx = ST_REQ;
                ST_REQ:  if (sample_ack || to_cnt == TO_LAST) state_nx = ST_WAIT;
                ST_WAIT: if (wt_cnt == WT_LAST) state_nx = ST_REQ;
                default: state_nx = ST_IDLE;
            endcase
        end
    end

    // An acknowledge on the last timeout cycle counts as a capture, not an expiry.
    always_comb begin
        sample_req = (state == ST_REQ);
        capture    = (state == ST_REQ) && enable && sample_ack;
        expire     = (state == ST_REQ) && enable && !sample_ack && (to_cnt == TO_LAST);
        fsm_state  = state;
    end

    // Counters advance only while staying in their state, so they stop at the terminal count.
    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt <= '0;
            wt_cnt <= '0;
        end else begin
            to_cnt <= (state == ST_REQ  && state_nx == ST_REQ)  ? to_cnt + 1'b1 : '0;
            wt_cnt <= (state == ST_WAIT && state_nx == ST_WAIT) ? wt_cnt + 1'b1 : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid   <= 1'b0;
            timeout <= 1'b0;
            c_f     <= 1'b0;
        end else begin
            if (capture) begin
                valid   <= 1'b1;
                timeout <= 1'b0;
            end else if (expire) begin
                timeout <= 1'b1;
            end
            if (units_toggle) c_f <= ~c_f;
        end
    end

`ifdef TEMP_AVG_EN
    temp_avg4 u_avg (
        .clk    (clk),
        .rst    (rst),
        .load   (capture),
        .sample (sample_data),
        .avg    (tc)
    );
`else
    always_ff @(posedge clk) begin
        if (rst)          tc <= '0;
        else if (capture) tc <= sample_data;
    end
`endif

endmodule

// File: tb/tb_temp_sample_ctrl.sv
// Directed self-checking bench for temp_sample_ctrl with SAMPLE_PERIOD=10, ACK_TIMEOUT=4.
// Expected tc values switch when TEMP_AVG_EN is defined.
module tb_temp_sample_ctrl;
    import temp_pkg::*;

    logic            clk;
    logic            rst;
    logic            enable;
    logic            units_toggle;
    logic            sample_req;
    logic            sample_ack;
    logic [TC_W-1:0] sample_data;
    logic [TC_W-1:0] tc;
    logic            c_f;
    logic            valid;
    logic            timeout;
    temp_state_t     fsm_state;

    int assert_cnt = 0;
    int fail_cnt   = 0;
    logic [TC_W-1:0] exp_q[$];
    logic [TC_W-1:0] tc_hold;
    logic [TC_W-1:0] exp_tc;

    temp_sample_ctrl #(
        .SAMPLE_PERIOD (10),
        .ACK_TIMEOUT   (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .units_toggle (units_toggle),
        .sample_req   (sample_req),
        .sample_ack   (sample_ack),
        .sample_data  (sample_data),
        .tc           (tc),
        .c_f          (c_f),
        .valid        (valid),
        .timeout      (timeout),
        .fsm_state    (fsm_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        assert_cnt++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic pulse_ack(input logic [TC_W-1:0] data);
        sample_ack  = 1'b1;
        sample_data = data;
        step();
        sample_ack  = 1'b0;
    endtask

    // Steps until sample_req rises (bounded) and checks the number of edges taken.
    task automatic wait_for_req(input string tag, input int exp_cycles);
        int n = 0;
        while (!sample_req && n < 40) begin
            step();
            n++;
        end
        check_eq(tag, n, exp_cycles);
    endtask

    initial begin
        rst = 1'b1; enable = 1'b1; units_toggle = 1'b0;
        sample_ack = 1'b0; sample_data = '0;
        step();
        step();
        check_eq("rst_req",     sample_req, 0);
        check_eq("rst_tc",      tc, 0);
        check_eq("rst_cf",      c_f, 0);
        check_eq("rst_valid",   valid, 0);
        check_eq("rst_timeout", timeout, 0);
        check_eq("rst_state",   fsm_state, ST_IDLE);

        rst = 1'b0;
        step();
        check_eq("first_req", sample_req, 1);

        // Normal sample: ack two cycles after the request
        step();
        pulse_ack(13'h1FFB);
        check_eq("ack_req_low", sample_req, 0);
        check_eq("ack_tc",      tc, 13'h1FFB);
        check_eq("ack_valid",   valid, 1);
        check_eq("ack_timeout", timeout, 0);
        check_eq("ack_state",   fsm_state, ST_WAIT);

        step();
        step();
        pulse_ack(13'h0AAA);
        check_eq("ack_in_wait_tc", tc, 13'h1FFB);
        wait_for_req("period_1", 7);

        // No acknowledge: request held exactly four cycles
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("to_req_high", sample_req, 1);
        end
        step();
        check_eq("to_req_low", sample_req, 0);
        check_eq("to_flag",    timeout, 1);
        check_eq("to_tc_hold", tc, 13'h1FFB);
        check_eq("to_valid",   valid, 1);
        wait_for_req("period_2", 10);

        // Acknowledge on the final timeout cycle wins
        step();
        step();
        step();
        check_eq("last_cycle_req", sample_req, 1);
        pulse_ack(13'h0019);
`ifdef TEMP_AVG_EN
        exp_tc = 13'd2;
`else
        exp_tc = 13'd25;
`endif
        check_eq("late_ack_tc",      tc, exp_tc);
        check_eq("late_ack_timeout", timeout, 0);
        check_eq("late_ack_req",     sample_req, 0);

        // Units toggles inside the wait period leave request timing alone
        for (int i = 0; i < 10; i++) begin
            units_toggle = (i == 2 || i == 6);
            step();
            units_toggle = 1'b0;
            if (i == 2) check_eq("cf_set", c_f, 1);
            if (i == 6) check_eq("cf_clr", c_f, 0);
            check_eq("units_req_timing", sample_req, (i == 9));
        end

        // Enable dropped during REQ; a late ack is ignored
        step();
        enable = 1'b0;
        step();
        check_eq("dis_req",   sample_req, 0);
        check_eq("dis_state", fsm_state, ST_IDLE);
        tc_hold = tc;
        pulse_ack(13'h0123);
        check_eq("dis_tc_hold", tc, tc_hold);
        check_eq("dis_valid",   valid, 1);
        check_eq("dis_timeout", timeout, 0);
        enable = 1'b1;
        step();
        check_eq("reen_req", sample_req, 1);

        // Reset mid-request discards a simultaneous ack
        rst = 1'b1;
        sample_ack = 1'b1;
        sample_data = 13'h0777;
        step();
        rst = 1'b0;
        sample_ack = 1'b0;
        check_eq("midrst_tc",    tc, 0);
        check_eq("midrst_valid", valid, 0);
        check_eq("midrst_req",   sample_req, 0);
        check_eq("midrst_state", fsm_state, ST_IDLE);
        step();
        check_eq("midrst_first_req", sample_req, 1);

        // Captures 8, -8, -8
`ifdef TEMP_AVG_EN
        exp_q.push_back(13'd8);
        exp_q.push_back(13'd4);
        exp_q.push_back(13'd0);
`else
        exp_q.push_back(13'd8);
        exp_q.push_back(13'h1FF8);
        exp_q.push_back(13'h1FF8);
`endif
        pulse_ack(13'd8);
        check_eq("seq_tc_0", tc, exp_q.pop_front());
        wait_for_req("period_3", 10);
        pulse_ack(13'h1FF8);
        check_eq("seq_tc_1", tc, exp_q.pop_front());
        wait_for_req("period_4", 10);
        pulse_ack(13'h1FF8);
        check_eq("seq_tc_2", tc, exp_q.pop_front());

        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule

// File: doc/temp_sample_ctrl.md
TEMP_SAMPLE_CTRL -- requirements
Module: temp_sample_ctrl

Interface
REQ-001 Parameter SAMPLE_PERIOD, default 100_000_000: number of cycles spent in WAIT between sample requests.
REQ-002 Parameter ACK_TIMEOUT, default 1000: maximum number of cycles sample_req stays high before the request is abandoned.
REQ-003 clk  in  1  the single clock; all state updates on its rising edge.
REQ-004 rst  in  1  synchronous reset, active-high.
REQ-005 enable  in  1  level; 1 = run periodic sampling.
REQ-006 units_toggle  in  1  single-cycle pulse, already debounced; flips the display units.
REQ-007 sample_req  out  1  registered request to the sensor reader.
REQ-008 sample_ack  in  1  single-cycle acknowledge; sample_data is valid in the same cycle.
REQ-009 sample_data  in  13  two's-complement temperature from the sensor reader.
REQ-010 tc  out  13  latched two's-complement temperature sent to the display converter.
REQ-011 c_f  out  1  units select: 0 = Celsius, 1 = Fahrenheit.
REQ-012 valid  out  1  high once at least one sample has been captured.
REQ-013 timeout  out  1  sticky flag: the last request got no acknowledge.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, REQ and WAIT.
REQ-015 IDLE SHALL go to REQ on the first edge with enable=1, so the first request goes out immediately.
REQ-016 In REQ, sample_req SHALL be 1; the SHALL be 0 in every other state.
REQ-017 In REQ, the timeout counter SHALL increment once per cycle.
REQ-018 sample_ack=1 in REQ SHALL, at the same edge, capture sample_data into tc, set valid=1, clear timeout, clear the wait counter and move to WAIT; sample_req goes low at that edge.
REQ-019 If ACK_TIMEOUT cycles pass in REQ with no acknowledge, the block SHALL move to WAIT, set timeout=1 and leave tc and valid unchanged.
REQ-020 If sample_ack arrives on the final timeout cycle, the acknowledge SHALL win.
REQ-021 In WAIT, the wait counter SHALL count 0..SAMPLE_PERIOD-1 and move to REQ on the terminal count.
REQ-022 sample_ack outside REQ SHALL be ignored.
REQ-023 enable=0 in any state SHALL force IDLE at the next edge; sample_req drops, counters clear, tc/valid/timeout/c_f hold.
REQ-024 c_f SHALL toggle one cycle after each units_toggle pulse, in any state, without affecting the FSM.
REQ-025 Both counters SHALL be sized by $clog2 of their parameter and SHALL never wrap past the terminal count.

Reset
REQ-026 When rst=1, state SHALL be IDLE and sample_req, tc, c_f, valid, timeout and all counters SHALL be 0.
REQ-027 Reset SHALL take priority over all other inputs, including mid-request; an acknowledge in the reset cycle is discarded.

Configuration
REQ-028 Macro TEMP_AVG_EN defined: tc SHALL be the running average of the last 4 captured samples.
- Samples are sign-extended to a 15-bit sum, then arithmetic-shifted right by 2.
- The first capture after reset fills all 4 entries with that sample.
REQ-029 Macro TEMP_AVG_EN undefined: tc SHALL be the latest captured sample and no averaging storage SHALL exist.

Structure
REQ-030 Package temp_pkg SHALL hold TC_W=13, the state enum type and the default period and timeout constants.
REQ-031 Sub-module temp_avg4 SHALL hold the 4-entry averager and SHALL be instantiated only under TEMP_AVG_EN.

Verification (SAMPLE_PERIOD=10, ACK_TIMEOUT=4)
REQ-032 Reset: rst=1 for 2 cycles with enable=1 -> all outputs 0; sample_req rises on the first edge after rst falls.
REQ-033 Normal sample: ack 2 cycles after req with data 13'h1FFB -> tc=13'h1FFB (-5), valid=1, req low at the ack edge; next req rises 10 cycles later.
REQ-034 No acknowledge -> req high exactly 4 cycles, then timeout=1 and tc stays 13'h1FFB; the next ack with 13'h0019 -> tc=25 and timeout=0.
REQ-035 Units and enable:
- units_toggle pulses at cycles 3 and 7 -> c_f=1 then 0; sample_req timing is unchanged.
- enable=0 during REQ -> req low next edge; a late ack is ignored and tc is unchanged.
REQ-036 With TEMP_AVG_EN, captures 8, -8, -8 -> tc = 8, then 4, then 0.
